// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_arbiter
// Brief   : Round-robin arbiter sharing one SPI master between two requesters.
// Revision: 1.0
// ============================================================================
module spi_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       p0_req,
    input  logic       p1_req,
    input  logic       p0_begin,
    input  logic       p1_begin,
    input  logic [7:0] p0_tx_data,
    input  logic [7:0] p1_tx_data,
    output logic       p0_gnt,
    output logic       p1_gnt,
    output logic       p0_done,
    output logic       p1_done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       spi_begin,
    output logic [7:0] spi_tx_data,
    input  logic       spi_ready,
    input  logic [7:0] spi_data
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_BUSY    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic [1:0]  r_done;
    logic        r_err;
    logic        r_spi_begin;
    logic [7:0]  r_rd;
    logic [7:0]  r_tx;

    logic        w_req;
    logic        w_begin;
    logic [7:0]  w_tx;
    logic        w_pick;
    logic        w_timeout;

    assign w_req     = r_owner ? p1_req     : p0_req;
    assign w_begin   = r_owner ? p1_begin   : p0_begin;
    assign w_tx      = r_owner ? p1_tx_data : p0_tx_data;
    // On a tie, the port that did not hold the bus last wins.
    assign w_pick    = (p0_req && p1_req) ? ~r_last : p1_req;
    assign w_timeout = (r_cnt == C_TIMEOUT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) w_next = S_GRANTED;
            end
            S_GRANTED: begin
                if (w_begin)     w_next = S_BUSY;
                else if (!w_req) w_next = S_IDLE;
            end
            S_BUSY: begin
                if (spi_ready)      w_next = w_req ? S_GRANTED : S_IDLE;
                else if (w_timeout) w_next = S_GRANTED;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 8'h00;
            r_done      <= 2'b00;
            r_err       <= 1'b0;
            r_spi_begin <= 1'b0;
            r_rd        <= 8'h00;
            r_tx        <= 8'h00;
        end else begin
            r_done      <= 2'b00;
            r_err       <= 1'b0;
            r_spi_begin <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) r_owner <= w_pick;
                end
                S_GRANTED: begin
                    if (w_begin) begin
                        r_spi_begin <= 1'b1;
                        r_tx        <= w_tx;
                        r_cnt       <= 8'h00;
                    end else if (!w_req) begin
                        r_last <= r_owner;
                    end
                end
                S_BUSY: begin
                    if (spi_ready) begin
                        r_rd   <= spi_data;
                        r_done <= r_owner ? 2'b10 : 2'b01;
                        if (!w_req) r_last <= r_owner;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign p0_gnt      = (r_state != S_IDLE) && !r_owner;
    assign p1_gnt      = (r_state != S_IDLE) &&  r_owner;
    assign p0_done     = r_done[0];
    assign p1_done     = r_done[1];
    assign err         = r_err;
    assign rd_data     = r_rd;
    assign spi_begin   = r_spi_begin;
    assign spi_tx_data = r_tx;

endmodule
`default_nettype wire
